// File: rtl/io_seg_scan.sv
// ---------------------------------------------------------------------------
// io_seg_scan
//   Drives an 8-digit multiplexed common-anode seven-segment display from the
//   data-memory I/O output ports. The value word is shown either in hex or in
//   decimal; decimal digits come from a sequential double-dabble converter
//   that performs one shift/adjust iteration per clock.
//
// Parameters
//   SCAN_DIV    io_clk cycles each digit stays lit (2 .. 2**20)
//
// Ports
//   io_clk      system clock, rising edge
//   reset       asynchronous, active-high
//   disp_value  value to display (out_port0)
//   disp_ctrl   [0] mode 0=hex 1=decimal, [1] blank all, [2] leading-zero
//               suppress (decimal only), [15:8] digit enable mask,
//               [23:16] decimal-point mask
//   seg_n       segments a..g on [0]..[6], active-low
//   dp_n        decimal point, active-low
//   an_n        digit select, active-low, bit 0 = rightmost digit
//   busy        decimal conversion in progress
//   overflow    last decimal result exceeded 99_999_999
// ---------------------------------------------------------------------------
module io_seg_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] disp_value,
  input  logic [31:0] disp_ctrl,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n,
  output logic        busy,
  output logic        overflow
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Buffer digit code: {dash, nibble}. A set dash bit overrides the nibble.
  localparam logic [4:0] DASH_CODE = 5'h10;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t           state;
  logic [31:0]      value_q;
  logic [31:0]      ctrl_q;
  logic [31:0]      last_value;
  logic             conv_valid;
  logic             req_q;
  logic [31:0]      shift_reg;
  logic [39:0]      bcd;
  logic [39:0]      bcd_adj;
  logic [4:0]       iter;
  logic [7:0][4:0]  disp_buf;
  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       idx;
  logic [2:0]       msd;
  logic             change;
  logic             start;
  logic             digit_blank;
  logic [7:0]       en_mask;
  logic [7:0]       dp_mask;
  logic [7:0]       an_sel;
  logic             unused_bits;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [39:0] bcd_adjust(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-low segment pattern, gfedcba order.
  function automatic logic [6:0] seg_decode(input logic [4:0] d);
    logic [6:0] s;
    if (d[4]) begin
      s = 7'b0111111;
    end else begin
      case (d[3:0])
        4'h0:    s = 7'b1000000;
        4'h1:    s = 7'b1111001;
        4'h2:    s = 7'b0100100;
        4'h3:    s = 7'b0110000;
        4'h4:    s = 7'b0011001;
        4'h5:    s = 7'b0010010;
        4'h6:    s = 7'b0000010;
        4'h7:    s = 7'b1111000;
        4'h8:    s = 7'b0000000;
        4'h9:    s = 7'b0010000;
        4'hA:    s = 7'b0001000;
        4'hB:    s = 7'b0000011;
        4'hC:    s = 7'b1000110;
        4'hD:    s = 7'b0100001;
        4'hE:    s = 7'b0000110;
        default: s = 7'b0001110;
      endcase
    end
    return s;
  endfunction

  assign en_mask     = ctrl_q[15:8];
  assign dp_mask     = ctrl_q[23:16];
  assign bcd_adj     = bcd_adjust(bcd);
  assign unused_bits = ^{ctrl_q[31:24], ctrl_q[7:3], bcd_adj[39]};

  // A conversion is wanted when no valid result exists or the value moved.
  // The request must be seen on two consecutive cycles (req_q plus the live
  // term), which lines the start up one cycle after value_q settles and
  // lets a change that arrived mid-conversion restart right after DONE.
  assign change = !conv_valid || (value_q != last_value);
  assign start  = (state == IDLE) && ctrl_q[0] && req_q && change;

  // Highest non-zero digit; digit 0 always counts as significant.
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (disp_buf[i][3:0] != 4'd0) begin
        msd = 3'(i);
      end
    end
  end

  always_comb begin
    digit_blank = ctrl_q[1] || !en_mask[idx] ||
                  (ctrl_q[0] && ctrl_q[2] && !overflow && (idx > msd));
    an_sel      = 8'd1 << idx;
  end

  // ---- input stage ----
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      ctrl_q  <= '0;
    end else begin
      value_q <= disp_value;
      ctrl_q  <= disp_ctrl;
    end
  end

  // ---- conversion control and display buffer ----
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      conv_valid <= 1'b0;
      req_q      <= 1'b0;
      disp_buf   <= '0;
    end else begin
      req_q <= ctrl_q[0] && change;
      if (!ctrl_q[0]) begin
        state      <= IDLE;
        busy       <= 1'b0;
        conv_valid <= 1'b0;
        for (int i = 0; i < 8; i++) begin
          disp_buf[i] <= {1'b0, value_q[4*i +: 4]};
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= CONV;
              busy  <= 1'b1;
            end
          end
          CONV: begin
            if (iter == 5'd31) begin
              state <= DONE;
            end
          end
          DONE: begin
            if (bcd[39:32] != 8'd0) begin
              overflow <= 1'b1;
              for (int i = 0; i < 8; i++) begin
                disp_buf[i] <= DASH_CODE;
              end
            end else begin
              overflow <= 1'b0;
              for (int i = 0; i < 8; i++) begin
                disp_buf[i] <= {1'b0, bcd[4*i +: 4]};
              end
            end
            conv_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---- double-dabble datapath ----
  always_ff @(posedge io_clk) begin
    if (start) begin
      last_value <= value_q;
      shift_reg  <= value_q;
      bcd        <= '0;
      iter       <= '0;
    end else if (state == CONV) begin
      bcd       <= {bcd_adj[38:0], shift_reg[31]};
      shift_reg <= {shift_reg[30:0], 1'b0};
      iter      <= iter + 5'd1;
    end
  end

  // ---- scan prescaler and digit index ----
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CNT_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // ---- output registers ----
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
      an_n  <= 8'hFF;
    end else begin
      an_n  <= digit_blank ? 8'hFF : ~an_sel;
      dp_n  <= digit_blank | ~dp_mask[idx];
      seg_n <= digit_blank ? 7'h7F : seg_decode(disp_buf[idx]);
    end
  end

endmodule

// File: tb/tb_io_seg_scan.sv
module tb_io_seg_scan;

  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic [31:0] disp_value;
  logic [31:0] disp_ctrl;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  // Reference model: what the display buffer should hold, as digit codes
  // 0..15 or 16 for a dash, plus the expected overflow flag.
  int          mbuf [8];
  logic        movf;
  logic [31:0] mctrl;

  io_seg_scan #(.SCAN_DIV(DIV)) dut (
    .io_clk    (clk),
    .reset     (rst),
    .disp_value(disp_value),
    .disp_ctrl (disp_ctrl),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset was released; drives the expected scan index.
  always @(posedge clk or posedge rst) begin
    if (rst) edges = 0;
    else     edges = edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic set_hex(input logic [31:0] v);
    for (int i = 0; i < 8; i++) mbuf[i] = int'((v >> (4 * i)) & 32'hF);
  endtask

  task automatic set_dec(input logic [31:0] v);
    int unsigned t;
    t = v;
    if (t > 99_999_999) begin
      movf = 1'b1;
      for (int i = 0; i < 8; i++) mbuf[i] = 16;
    end else begin
      movf = 1'b0;
      for (int i = 0; i < 8; i++) begin
        mbuf[i] = int'(t % 10);
        t = t / 10;
      end
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] v, input logic [31:0] c);
    disp_value = v;
    disp_ctrl  = c;
    mctrl      = c;
  endtask

  // Compare the currently lit digit against the model.
  task automatic check_now(input string base);
    int   idx;
    int   msd;
    logic blank;
    logic [7:0] sel;
    idx = ((edges - 1) / DIV) % 8;
    msd = 0;
    for (int i = 1; i < 8; i++) if (mbuf[i] != 0) msd = i;
    blank = mctrl[1] || !mctrl[8 + idx] ||
            (mctrl[0] && mctrl[2] && !movf && (idx > msd));
    sel = 8'd1 << idx;
    chk($sformatf("%s_an_d%0d", base, idx), {24'd0, an_n}, blank ? 32'hFF : {24'd0, ~sel});
    chk($sformatf("%s_dp_d%0d", base, idx), {31'd0, dp_n}, {31'd0, blank | ~mctrl[16 + idx]});
    if (!blank)
      chk($sformatf("%s_seg_d%0d", base, idx), {25'd0, seg_n}, {25'd0, seg_of(mbuf[idx])});
    chk($sformatf("%s_ovf", base), {31'd0, overflow}, {31'd0, movf});
  endtask

  // One full pass over all eight digits with the converter idle.
  task automatic scan_check(input string base);
    for (int c = 0; c < 8 * DIV; c++) begin
      wait_n(1);
      check_now(base);
      chk({base, "_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rv;
    logic [31:0] rc;
    logic        seen;

    rst = 1'b1;
    movf = 1'b0;
    for (int i = 0; i < 8; i++) mbuf[i] = 0;
    drive(32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_seg",  {25'd0, seg_n},   32'h7F);
    chk("rst_dp",   {31'd0, dp_n},    32'd1);
    chk("rst_an",   {24'd0, an_n},    32'hFF);
    chk("rst_busy", {31'd0, busy},    32'd0);
    chk("rst_ovf",  {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    // Hex display of 89ABCDEF, all digits enabled.
    drive(32'h89ABCDEF, 32'h0000FF00);
    set_hex(32'h89ABCDEF);
    wait_n(3);
    scan_check("hex");

    // Decimal 12345 with leading-zero suppression: exact busy window and
    // buffer update 35 edges after value_q samples the value.
    drive(32'd12345, 32'h0000FF05);
    for (int k = 1; k <= 37; k++) begin
      wait_n(1);
      if (k == 37) set_dec(32'd12345);
      chk($sformatf("dec_busy_e%0d", k - 1), {31'd0, busy},
          {31'd0, ((k - 1) >= 2) && ((k - 1) <= 34)});
      check_now($sformatf("dec_e%0d", k - 1));
    end
    scan_check("dec12345");

    // Overflow shows dashes on every digit, then clears on a small value.
    drive(32'd100_000_000, 32'h0000FF05);
    wait_n(40);
    set_dec(32'd100_000_000);
    scan_check("ovf");
    drive(32'd7, 32'h0000FF05);
    wait_n(40);
    set_dec(32'd7);
    scan_check("seven");

    // Value changes mid-conversion: first result lands, second follows.
    drive(32'd12345, 32'h0000FF05);
    wait_n(7);
    disp_value = 32'd999;
    wait_n(29);
    chk("b2b_busy_e35", {31'd0, busy}, 32'd0);
    check_now("b2b_e35");
    wait_n(1);
    set_dec(32'd12345);
    chk("b2b_busy_e36", {31'd0, busy}, 32'd1);
    check_now("b2b_e36");
    wait_n(33);
    chk("b2b_busy_e69", {31'd0, busy}, 32'd0);
    check_now("b2b_e69");
    wait_n(1);
    set_dec(32'd999);
    check_now("b2b_e70");
    scan_check("b2b999");

    // Randomized decimal values, some of them overflowing.
    for (int r = 0; r < 6; r++) begin
      rv = (r % 2 == 1) ? $urandom : $urandom_range(0, 99_999_999);
      rc = {8'h00, 8'($urandom), 8'($urandom), 5'd0, 1'($urandom), 2'b01};
      drive(rv, rc);
      wait_n(40);
      set_dec(rv);
      scan_check($sformatf("rdec%0d", r));
    end

    // Randomized hex values; overflow keeps its last value.
    for (int r = 0; r < 4; r++) begin
      rv = $urandom;
      rc = {8'h00, 8'($urandom), 8'($urandom), 5'd0, 1'($urandom),
            ($urandom_range(0, 3) == 0), 1'b0};
      drive(rv, rc);
      wait_n(3);
      set_hex(rv);
      scan_check($sformatf("rhex%0d", r));
    end

    // Reset in the middle of a conversion.
    drive(32'd3_000_000_000, 32'h0000FF05);
    wait_n(40);
    set_dec(32'd3_000_000_000);
    scan_check("preovf");
    drive(32'd4321, 32'h0000FF05);
    wait_n(10);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_an",   {24'd0, an_n},     32'hFF);
    chk("arst_seg",  {25'd0, seg_n},    32'h7F);
    chk("arst_dp",   {31'd0, dp_n},     32'd1);
    chk("arst_busy", {31'd0, busy},     32'd0);
    chk("arst_ovf",  {31'd0, overflow}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    movf = 1'b0;
    for (int i = 0; i < 8; i++) mbuf[i] = 0;
    wait_n(5);
    check_now("post_rst");
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      wait_n(1);
      if (busy) seen = 1'b1;
      if (seen && !busy) break;
    end
    chk("restart_seen", {31'd0, seen}, 32'd1);
    chk("restart_done", {31'd0, busy}, 32'd0);
    set_dec(32'd4321);
    wait_n(2);
    scan_check("restart");

    // Blank-all overrides masks; single decimal point on digit 2.
    drive(32'h13572468, 32'h00FFFF02);
    set_hex(32'h13572468);
    wait_n(3);
    scan_check("blank");
    drive(32'h13572468, 32'h0004FF00);
    wait_n(3);
    scan_check("dp2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
